fb_write_arbiter: RTL
=====================

Name: fb_write_arbiter

Overview:
- Single owner of the framebuffer RAM write port: 640x480 pixels, 19-bit address, 8-bit pixel code, written on CLOCK_50.
- Shares the port between player 1 and player 2 trail writers using round-robin arbitration.
- Owns a clear sweeper that zeroes the whole buffer after reset and on each restart request.
- Sits between the jogador modules and the RAM wraddress/data/wren pins.

Parameters:
ADDR_W, 19, write address width
DATA_W, 8, pixel code width
FB_WORDS, 307200, framebuffer depth (640*480); legal addresses 0..FB_WORDS-1
CLEAR_VALUE, 8'h00, pixel code written by the clear sweep

Ports:
CLOCK_50  in  1  single clock; all state on its rising edge
reset  in  1  synchronous, active-high
clear_req  in  1  restart request (level, e.g. the reiniciar switch); rising edge starts a sweep
p1_req  in  1  player 1 write request
p1_addr  in  ADDR_W  player 1 pixel address
p1_data  in  DATA_W  player 1 pixel code
p1_gnt  out  1  player 1 request accepted this cycle (combinational)
p2_req  in  1  player 2 write request
p2_addr  in  ADDR_W  player 2 pixel address
p2_data  in  DATA_W  player 2 pixel code
p2_gnt  out  1  player 2 request accepted this cycle (combinational)
wr_en  out  1  RAM write enable (registered)
wr_addr  out  ADDR_W  RAM write address (registered)
wr_data  out  DATA_W  RAM write data (registered)
clear_busy  out  1  sweep in progress
clear_done  out  1  one-cycle pulse when a sweep completes
collision  out  1  same-address conflict pulse; tied 0 when the optional feature is off

Behaviour:
Reset:
- While reset is high: wr_en=0, wr_addr=0, wr_data=0, clear_done=0, collision=0, gnt=0, round-robin pointer=P1, clear_req edge detector loaded with the current clear_req level.
- First cycle after reset deasserts: state=CLEAR, sweep counter=0, clear_busy=1. The buffer is always cleared after reset.

FSM states:
- CLEAR -> SERVE when the counter reaches FB_WORDS-1.
- SERVE -> CLEAR on a clear_req rising edge, counter reloaded to 0.

CLEAR:
- One write per cycle: wr_en=1, wr_addr=counter, wr_data=CLEAR_VALUE.
- Total FB_WORDS writes, contiguous, no gaps.
- p1_gnt=p2_gnt=0 throughout.
- clear_req edges are ignored.
- clear_done pulses in the cycle after the final write (addr FB_WORDS-1) is presented on wr_*; clear_busy falls in that same cycle.

SERVE handshake:
- pN_gnt=pN_req AND the arbiter selects N, evaluated combinationally in cycle T.
- The accepted write appears on wr_* in T+1 (latency 1).
- A requester holds req/addr/data stable until it sees gnt high; it may change them on the next edge.

Arbitration:
- One request only: granted.
- Both requesting: grant the player not pointed at by last-granted, then move the pointer to the winner. The loser keeps req high and wins next cycle.
- No request: wr_en=0 next cycle; wr_addr/wr_data hold.

Boundary cases:
- Address >= FB_WORDS: request is still granted (consumed), but wr_en=0 next cycle. No out-of-range write ever reaches the RAM.
- clear_req rising edge and a player request in the same SERVE cycle: clear wins. No grant that cycle; CLEAR starts next cycle.
- Reset mid-sweep: sweep aborts and restarts from address 0 after reset.
- Counter width: ADDR_W, comparing against FB_WORDS-1, never wraps.

Optional Feature:
FB_WRITE_COLLISION_EN
- Defined: when both players request the SAME in-range address in the same SERVE cycle, both gnt are asserted. Only the round-robin winner's data is written at T+1, the pointer advances, and collision pulses high at T+1 with that write. Used by game logic to detect a head-on crash.
- Undefined: equal addresses are arbitrated like any other conflict (loser waits a cycle), and collision is constant 0.

Decomposition:
- Package fb_pkg holds:
  - FB_WIDTH=640, FB_HEIGHT=480, FB_WORDS, ADDR_W, DATA_W
  - pixel codes PIX_EMPTY=0, PIX_JOG1=1, PIX_JOG2=2
  - FSM state encoding (CLEAR, SERVE) and round-robin pointer enum (P1, P2)
- One sub-module, fb_clear_sweeper, holds the address counter with start/busy/done. It keeps the arbiter top at mux, pointer and FSM.

Test Plan:
- Reset 3 cycles then release -> wr_en high for exactly 307200 consecutive cycles, addr 0..307199 in order, data 0x00. clear_done pulses once; gnts 0 throughout.
- After clear, p1_req alone with addr=153816 (216+240*640), data=1 -> p1_gnt=1 same cycle. Next cycle wr_en=1, wr_addr=153816, wr_data=1.
- Both players hold requests, addr 100 and 200, for 4 cycles -> grants alternate P2,P1,P2,P1 (pointer starts at P1). wr_addr sequence 200,100,200,100.
- p2_req with addr=307200 -> p2_gnt=1, next cycle wr_en=0.
- clear_req 0->1 while p1_req is high -> p1_gnt=0 that cycle and a full sweep follows. Holding clear_req high does not retrigger; a 1->0->1 toggle after clear_done does.
- With FB_WRITE_COLLISION_EN, both players addr=5000 with data 1 and 2, pointer=P1 -> both gnt=1. Next cycle wr_data=2 and collision=1. Without the macro, two writes occur over two cycles and collision stays 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel codes and arbiter state encodings.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int unsigned FB_WORDS  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned DATA_W    = 8;

  localparam logic [DATA_W-1:0] PIX_EMPTY = 8'h00;
  localparam logic [DATA_W-1:0] PIX_JOG1  = 8'h01;
  localparam logic [DATA_W-1:0] PIX_JOG2  = 8'h02;

  typedef enum logic {
    CLEAR,
    SERVE
  } fb_state_t;

  typedef enum logic {
    P1,
    P2
  } rr_ptr_t;

endpackage

// File: rtl/fb_clear_sweeper.sv
// Address counter for the framebuffer clear sweep, with busy/done status.
module fb_clear_sweeper #(
  parameter int unsigned ADDR_W   = fb_pkg::ADDR_W,
  parameter int unsigned FB_WORDS = fb_pkg::FB_WORDS
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  assign last_c = (addr == LAST_ADDR);

  // busy trails run by one cycle so it covers the final write on the RAM pins
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      addr <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else begin
      if (start) begin
        addr <= '0;
      end else if (run && !last_c) begin
        addr <= addr + ADDR_W'(1);
      end
      busy <= start || run;
      done <= busy && !run && !start;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: clear sweep plus round-robin P1/P2 trail writes.
// Optional macro FB_WRITE_COLLISION_EN grants both players on a same-address clash.
module fb_write_arbiter #(
  parameter int unsigned          ADDR_W      = fb_pkg::ADDR_W,
  parameter int unsigned          DATA_W      = fb_pkg::DATA_W,
  parameter int unsigned          FB_WORDS    = fb_pkg::FB_WORDS,
  parameter logic [DATA_W-1:0]    CLEAR_VALUE = DATA_W'(fb_pkg::PIX_EMPTY)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  input  logic              p2_req,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_data,
  output logic              p2_gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              collision
);

  import fb_pkg::*;

  localparam logic [ADDR_W:0] WORDS_X = (ADDR_W + 1)'(FB_WORDS);

  fb_state_t         state;
  fb_state_t         state_nxt;
  rr_ptr_t           rr_ptr;
  logic              clear_q;
  logic              clear_rise_c;
  logic              serve_c;
  logic              sel_p2_c;
  logic              coll_c;
  logic              start_c;
  logic              win_in_range_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_data_c;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_last_c;

  fb_clear_sweeper #(
    .ADDR_W   (ADDR_W),
    .FB_WORDS (FB_WORDS)
  ) u_sweeper (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start_c),
    .run      (state == CLEAR),
    .addr     (sweep_addr),
    .last_c   (sweep_last_c),
    .busy     (clear_busy),
    .done     (clear_done)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grants and winner mux; a clear edge pre-empts any grant
  always_comb begin
    state_nxt      = state;
    clear_rise_c   = clear_req && !clear_q;
    serve_c        = 1'b0;
    start_c        = 1'b0;
    coll_c         = 1'b0;
    p1_gnt         = 1'b0;
    p2_gnt         = 1'b0;
    win_addr_c     = p1_addr;
    win_data_c     = p1_data;
    win_in_range_c = 1'b0;

    case (state)
      CLEAR: begin
        if (sweep_last_c) state_nxt = SERVE;
      end
      SERVE: begin
        if (clear_rise_c) begin
          state_nxt = CLEAR;
          start_c   = 1'b1;
        end else begin
          serve_c = !reset;
        end
      end
    endcase

    sel_p2_c = p2_req && (!p1_req || (rr_ptr == P1));
`ifdef FB_WRITE_COLLISION_EN
    coll_c = p1_req && p2_req && (p1_addr == p2_addr) && ({1'b0, p1_addr} < WORDS_X);
`endif
    if (serve_c) begin
      p1_gnt = p1_req && (!sel_p2_c || coll_c);
      p2_gnt = sel_p2_c;
    end
    if (sel_p2_c) begin
      win_addr_c = p2_addr;
      win_data_c = p2_data;
    end
    win_in_range_c = ({1'b0, win_addr_c} < WORDS_X);
  end

  // Out-of-range grants are consumed without touching the RAM pins
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      collision <= 1'b0;
      rr_ptr    <= P1;
      clear_q   <= clear_req;
    end else begin
      clear_q   <= clear_req;
      wr_en     <= 1'b0;
      collision <= 1'b0;
      if (state == CLEAR) begin
        wr_en   <= 1'b1;
        wr_addr <= sweep_addr;
        wr_data <= CLEAR_VALUE;
      end else if (p1_gnt || p2_gnt) begin
        rr_ptr <= sel_p2_c ? P2 : P1;
        if (win_in_range_c) begin
          wr_en     <= 1'b1;
          wr_addr   <= win_addr_c;
          wr_data   <= win_data_c;
          collision <= coll_c;
        end
      end
    end
  end

endmodule
